// File: rtl/juiz_pkg.sv
// juiz_pkg: shared definitions for the invader-game referee (juiz_frota).
//   estado_t   - referee FSM states
//   N_INIMIGOS - enemy/bullet slots carried on the fleet bus
//   LARG_CAMPO - width of one coordinate field on the bus
//   LARG_BUS   - width of one packed coordinate bus
//   ALT_TELA   - screen height; a bullet at or below this row is not live
//   LARG_TELA  - screen width
package juiz_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT,
    FIM
  } estado_t;

  localparam int unsigned N_INIMIGOS = 20;
  localparam int unsigned LARG_CAMPO = 10;
  localparam int unsigned LARG_BUS   = N_INIMIGOS * LARG_CAMPO;
  localparam int unsigned ALT_TELA   = 480;
  localparam int unsigned LARG_TELA  = 640;

endpackage

// File: rtl/juiz_frota_if.sv
// juiz_frota_if: packed fleet bus from the fleet block to the referee.
//   inimigo_x/inimigo_y - enemy positions, slot i at [10i+9:10i]
//   x_bola/y_bola       - enemy bullet positions, slot i at [10i+9:10i]
//   vivo                - bit i set while enemy i is alive
//   x_nave/y_nave       - ship top-left corner
// Modports: master = fleet block (drives), slave = referee (reads).
interface juiz_frota_if;
  import juiz_pkg::*;

  logic [LARG_BUS-1:0]   inimigo_x;
  logic [LARG_BUS-1:0]   inimigo_y;
  logic [LARG_BUS-1:0]   x_bola;
  logic [LARG_BUS-1:0]   y_bola;
  logic [0:N_INIMIGOS-1] vivo;
  logic [LARG_CAMPO-1:0] x_nave;
  logic [LARG_CAMPO-1:0] y_nave;

  modport master (
    output inimigo_x, inimigo_y, x_bola, y_bola, vivo, x_nave, y_nave
  );

  modport slave (
    input inimigo_x, inimigo_y, x_bola, y_bola, vivo, x_nave, y_nave
  );

endinterface

// File: rtl/colisao_caixa.sv
// colisao_caixa: combinational axis-aligned box overlap test on 11-bit coordinates.
//   a_x_i, a_y_i, a_larg_i, a_alt_i - box A top-left, width, height
//   b_x_i, b_y_i, b_larg_i, b_alt_i - box B top-left, width, height
//   sobrepoe_o                      - boxes share at least one pixel
// Inputs come from 10-bit fields plus small sizes, so the 11-bit sums never wrap.
module colisao_caixa (
  input  logic [10:0] a_x_i,
  input  logic [10:0] a_y_i,
  input  logic [10:0] a_larg_i,
  input  logic [10:0] a_alt_i,
  input  logic [10:0] b_x_i,
  input  logic [10:0] b_y_i,
  input  logic [10:0] b_larg_i,
  input  logic [10:0] b_alt_i,
  output logic        sobrepoe_o
);

  logic sob_x;
  logic sob_y;

  always_comb begin
    sob_x      = (a_x_i < b_x_i + b_larg_i) && (a_x_i + a_larg_i > b_x_i);
    sob_y      = (a_y_i < b_y_i + b_alt_i) && (a_y_i + a_alt_i > b_y_i);
    sobrepoe_o = sob_x && sob_y;
  end

endmodule

// File: rtl/juiz_frota.sv
// juiz_frota: referee for the invader game.
// On each accepted movement tick it snapshots the fleet bus, scans the 20 slots one per
// cycle, then updates lives, score and end-of-game flags in a single REPORT cycle.
//   CLOCK_50      - system clock
//   reset         - asynchronous, active-low
//   tick_mv       - one-cycle frame pulse; accepted only in IDLE with pausa low
//   pausa         - drops ticks while high (does not stall a scan in progress)
//   reiniciarJogo - synchronous restart, priority over everything else
//   frota         - fleet bus (slave modport)
//   vidas, pontos, acerto_nave, fim_jogo, vitoria, ocupado - registered HUD/control outputs
// Build option: define JUIZ_INVASAO_EN to compile in the enemy-invasion loss check.
module juiz_frota
  import juiz_pkg::*;
#(
  parameter int unsigned VIDAS_INI   = 3,
  parameter int unsigned LARG_NAVE   = 32,
  parameter int unsigned ALT_NAVE    = 16,
  parameter int unsigned TAM_BOLA    = 4
`ifdef JUIZ_INVASAO_EN
  ,
  parameter int unsigned ALT_INIMIGO = 16
`endif
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             tick_mv,
  input  logic             pausa,
  input  logic             reiniciarJogo,
  juiz_frota_if.slave      frota,
  output logic [1:0]       vidas,
  output logic [7:0]       pontos,
  output logic             acerto_nave,
  output logic             fim_jogo,
  output logic             vitoria,
  output logic             ocupado
);

  estado_t estado_q, estado_d;
  logic [4:0] cont_q, cont_d;

  // Snapshot shift registers: the slot under test is always in the low field.
  logic [LARG_BUS-1:0]   x_bola_q, x_bola_d;
  logic [LARG_BUS-1:0]   y_bola_q, y_bola_d;
  logic [N_INIMIGOS-1:0] vivo_q, vivo_d;
  logic [LARG_CAMPO-1:0] x_nave_q, x_nave_d;
  logic [LARG_CAMPO-1:0] y_nave_q, y_nave_d;

  // Per-frame accumulators.
  logic       acerto_q, acerto_d;
  logic [4:0] mortos_q, mortos_d;
`ifdef JUIZ_INVASAO_EN
  logic [LARG_BUS-1:0] inimigo_y_q, inimigo_y_d;
  logic                invasao_q, invasao_d;
`endif

  logic [1:0] vidas_q, vidas_d;
  logic [7:0] pontos_q, pontos_d;
  logic       acerto_nave_q, acerto_nave_d;
  logic       fim_q, fim_d;
  logic       vitoria_q, vitoria_d;
  logic       ocupado_q, ocupado_d;

  logic       bola_viva;
  logic       bola_na_nave;
  logic [1:0] vidas_nova;
  logic       perde_jogo;

  assign bola_viva = {1'b0, y_bola_q[LARG_CAMPO-1:0]} < 11'(ALT_TELA);

  // Saturating: a hit at zero lives keeps zero.
  assign vidas_nova = (acerto_q && (vidas_q != 2'd0)) ? vidas_q - 2'd1 : vidas_q;

`ifdef JUIZ_INVASAO_EN
  assign perde_jogo = (vidas_nova == 2'd0) || invasao_q;
`else
  assign perde_jogo = (vidas_nova == 2'd0);
`endif

  colisao_caixa u_colisao (
    .a_x_i    ({1'b0, x_bola_q[LARG_CAMPO-1:0]}),
    .a_y_i    ({1'b0, y_bola_q[LARG_CAMPO-1:0]}),
    .a_larg_i (11'(TAM_BOLA)),
    .a_alt_i  (11'(TAM_BOLA)),
    .b_x_i    ({1'b0, x_nave_q}),
    .b_y_i    ({1'b0, y_nave_q}),
    .b_larg_i (11'(LARG_NAVE)),
    .b_alt_i  (11'(ALT_NAVE)),
    .sobrepoe_o(bola_na_nave)
  );

  always_comb begin
    estado_d      = estado_q;
    cont_d        = cont_q;
    x_bola_d      = x_bola_q;
    y_bola_d      = y_bola_q;
    vivo_d        = vivo_q;
    x_nave_d      = x_nave_q;
    y_nave_d      = y_nave_q;
    acerto_d      = acerto_q;
    mortos_d      = mortos_q;
`ifdef JUIZ_INVASAO_EN
    inimigo_y_d   = inimigo_y_q;
    invasao_d     = invasao_q;
`endif
    vidas_d       = vidas_q;
    pontos_d      = pontos_q;
    acerto_nave_d = 1'b0;
    fim_d         = fim_q;
    vitoria_d     = vitoria_q;

    unique case (estado_q)
      IDLE: begin
        if (tick_mv && !pausa) begin
          x_bola_d = frota.x_bola;
          y_bola_d = frota.y_bola;
          for (int i = 0; i < N_INIMIGOS; i++) begin
            vivo_d[i] = frota.vivo[i];
          end
          x_nave_d = frota.x_nave;
          y_nave_d = frota.y_nave;
`ifdef JUIZ_INVASAO_EN
          inimigo_y_d = frota.inimigo_y;
          invasao_d   = 1'b0;
`endif
          acerto_d = 1'b0;
          mortos_d = 5'd0;
          cont_d   = 5'd0;
          estado_d = SCAN;
        end
      end

      SCAN: begin
        if (bola_viva && bola_na_nave) begin
          acerto_d = 1'b1;
        end
        if (!vivo_q[0]) begin
          mortos_d = mortos_q + 5'd1;
        end
`ifdef JUIZ_INVASAO_EN
        if (vivo_q[0] &&
            ({1'b0, inimigo_y_q[LARG_CAMPO-1:0]} + 11'(ALT_INIMIGO) >= {1'b0, y_nave_q})) begin
          invasao_d = 1'b1;
        end
        inimigo_y_d = inimigo_y_q >> LARG_CAMPO;
`endif
        x_bola_d = x_bola_q >> LARG_CAMPO;
        y_bola_d = y_bola_q >> LARG_CAMPO;
        vivo_d   = vivo_q >> 1;
        cont_d   = cont_q + 5'd1;
        if (cont_q == 5'(N_INIMIGOS - 1)) begin
          estado_d = REPORT;
        end
      end

      REPORT: begin
        vidas_d       = vidas_nova;
        acerto_nave_d = acerto_q;
        // Score is dead * 10 as shift-and-add.
        pontos_d      = {mortos_q, 3'b000} + {2'b00, mortos_q, 1'b0};
        if (mortos_q == 5'(N_INIMIGOS)) begin
          fim_d     = 1'b1;
          vitoria_d = 1'b1;
          estado_d  = FIM;
        end else if (perde_jogo) begin
          fim_d     = 1'b1;
          vitoria_d = 1'b0;
          estado_d  = FIM;
        end else begin
          estado_d  = IDLE;
        end
      end

      FIM: begin
        // Held until restart; ticks ignored.
      end

      default: estado_d = IDLE;
    endcase

    if (reiniciarJogo) begin
      estado_d      = IDLE;
      cont_d        = 5'd0;
      acerto_d      = 1'b0;
      mortos_d      = 5'd0;
`ifdef JUIZ_INVASAO_EN
      invasao_d     = 1'b0;
`endif
      vidas_d       = 2'(VIDAS_INI);
      pontos_d      = 8'd0;
      acerto_nave_d = 1'b0;
      fim_d         = 1'b0;
      vitoria_d     = 1'b0;
    end

    ocupado_d = (estado_d == SCAN) || (estado_d == REPORT);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      estado_q      <= IDLE;
      cont_q        <= 5'd0;
      x_bola_q      <= '0;
      y_bola_q      <= '0;
      vivo_q        <= '0;
      x_nave_q      <= '0;
      y_nave_q      <= '0;
      acerto_q      <= 1'b0;
      mortos_q      <= 5'd0;
`ifdef JUIZ_INVASAO_EN
      inimigo_y_q   <= '0;
      invasao_q     <= 1'b0;
`endif
      vidas_q       <= 2'(VIDAS_INI);
      pontos_q      <= 8'd0;
      acerto_nave_q <= 1'b0;
      fim_q         <= 1'b0;
      vitoria_q     <= 1'b0;
      ocupado_q     <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      cont_q        <= cont_d;
      x_bola_q      <= x_bola_d;
      y_bola_q      <= y_bola_d;
      vivo_q        <= vivo_d;
      x_nave_q      <= x_nave_d;
      y_nave_q      <= y_nave_d;
      acerto_q      <= acerto_d;
      mortos_q      <= mortos_d;
`ifdef JUIZ_INVASAO_EN
      inimigo_y_q   <= inimigo_y_d;
      invasao_q     <= invasao_d;
`endif
      vidas_q       <= vidas_d;
      pontos_q      <= pontos_d;
      acerto_nave_q <= acerto_nave_d;
      fim_q         <= fim_d;
      vitoria_q     <= vitoria_d;
      ocupado_q     <= ocupado_d;
    end
  end

  assign vidas       = vidas_q;
  assign pontos      = pontos_q;
  assign acerto_nave = acerto_nave_q;
  assign fim_jogo    = fim_q;
  assign vitoria     = vitoria_q;
  assign ocupado     = ocupado_q;

endmodule

// File: tb/tb_juiz_frota.sv
// tb_juiz_frota: self-checking bench for juiz_frota.
// Directed frames follow the game scenarios (no hit, single and multiple hits, loss, win,
// sticky end, pause, restart mid-scan, dropped tick), then randomized frames are checked
// against a frame-level reference model of the referee rules.
module tb_juiz_frota;

  localparam int N = 20;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       tick_mv;
  logic       pausa;
  logic       reiniciarJogo;
  logic [1:0] vidas;
  logic [7:0] pontos;
  logic       acerto_nave;
  logic       fim_jogo;
  logic       vitoria;
  logic       ocupado;

  juiz_frota_if frota ();

  juiz_frota dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .tick_mv      (tick_mv),
    .pausa        (pausa),
    .reiniciarJogo(reiniciarJogo),
    .frota        (frota),
    .vidas        (vidas),
    .pontos       (pontos),
    .acerto_nave  (acerto_nave),
    .fim_jogo     (fim_jogo),
    .vitoria      (vitoria),
    .ocupado      (ocupado)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;

  // Bus contents as plain integers.
  int ex[N];
  int ey[N];
  int bx[N];
  int by[N];
  bit ev[N];
  int xn;
  int yn;

  // Reference state.
  int m_vidas;
  int m_pontos;
  bit m_fim;
  bit m_vit;
  bit m_acerto;

  task automatic verifica(input string tag, input int obs, input int esp);
    total++;
    if (obs != esp) begin
      bad++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, esp);
    end
  endtask

  task automatic empacota();
    for (int i = 0; i < N; i++) begin
      frota.inimigo_x[10*i +: 10] = 10'(ex[i]);
      frota.inimigo_y[10*i +: 10] = 10'(ey[i]);
      frota.x_bola[10*i +: 10]    = 10'(bx[i]);
      frota.y_bola[10*i +: 10]    = 10'(by[i]);
      frota.vivo[i]               = ev[i];
    end
    frota.x_nave = 10'(xn);
    frota.y_nave = 10'(yn);
  endtask

  // Quiet field: everyone alive high up, every bullet off screen.
  task automatic limpa();
    for (int i = 0; i < N; i++) begin
      ex[i] = 30 * i;
      ey[i] = 50;
      bx[i] = 0;
      by[i] = 480;
      ev[i] = 1'b1;
    end
    xn = 300;
    yn = 420;
  endtask

  task automatic gera_aleatorio();
    bit todos_mortos;
    todos_mortos = ($urandom_range(0, 14) == 0);
    xn = int'($urandom_range(0, 600));
    yn = int'($urandom_range(380, 460));
    for (int i = 0; i < N; i++) begin
      ex[i] = int'($urandom_range(0, 620));
      ey[i] = ($urandom_range(0, 29) == 0) ? int'($urandom_range(300, 470))
                                           : int'($urandom_range(0, 250));
      ev[i] = todos_mortos ? 1'b0 : ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) begin
        bx[i] = xn - 8 + int'($urandom_range(0, 44));
        by[i] = yn - 8 + int'($urandom_range(0, 28));
        if (bx[i] < 0) bx[i] = 0;
      end else if ($urandom_range(0, 5) == 0) begin
        bx[i] = int'($urandom_range(0, 639));
        by[i] = int'($urandom_range(0, 479));
      end else begin
        bx[i] = int'($urandom_range(0, 1023));
        by[i] = int'($urandom_range(480, 1023));
      end
    end
  endtask

  // One whole frame evaluated from the game rules on the current bus contents.
  function automatic void modelo_quadro();
    int  mortos;
    bit  hit;
    bit  inv;
    mortos = 0;
    hit    = 1'b0;
    inv    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (by[i] < 480 && bx[i] < xn + 32 && bx[i] + 4 > xn && by[i] < yn + 16 && by[i] + 4 > yn)
        hit = 1'b1;
      if (!ev[i]) mortos++;
`ifdef JUIZ_INVASAO_EN
      if (ev[i] && ey[i] + 16 >= yn) inv = 1'b1;
`endif
    end
    m_acerto = hit;
    if (hit && m_vidas > 0) m_vidas--;
    m_pontos = 10 * mortos;
    if (mortos == N) begin
      m_fim = 1'b1;
      m_vit = 1'b1;
    end else if (m_vidas == 0 || inv) begin
      m_fim = 1'b1;
      m_vit = 1'b0;
    end
  endfunction

  task automatic confere(input string nome);
    verifica({nome, "_vidas"}, int'(vidas), m_vidas);
    verifica({nome, "_pontos"}, int'(pontos), m_pontos);
    verifica({nome, "_acerto"}, int'(acerto_nave), int'(m_acerto));
    verifica({nome, "_fim"}, int'(fim_jogo), int'(m_fim));
    verifica({nome, "_vitoria"}, int'(vitoria), int'(m_vit));
    verifica({nome, "_ocupado"}, int'(ocupado), 0);
  endtask

  // Starts at a falling edge in cycle 0 and returns at the falling edge of cycle 23.
  task automatic quadro(input string nome, input bit embaralha);
    bit ativo;
    ativo = !m_fim && !pausa;
    empacota();
    if (ativo) modelo_quadro();
    else m_acerto = 1'b0;
    tick_mv = 1'b1;
    @(negedge CLOCK_50);
    tick_mv = 1'b0;
    verifica({nome, "_ocupado_c1"}, int'(ocupado), int'(ativo));
    if (embaralha) begin
      gera_aleatorio();
      empacota();
      pausa = ($urandom_range(0, 3) == 0);
    end
    repeat (20) @(negedge CLOCK_50);
    verifica({nome, "_acerto_c21"}, int'(acerto_nave), 0);
    @(negedge CLOCK_50);
    pausa = 1'b0;
    confere(nome);
    @(negedge CLOCK_50);
    verifica({nome, "_acerto_c23"}, int'(acerto_nave), 0);
  endtask

  task automatic reinicia(input string nome);
    reiniciarJogo = 1'b1;
    @(negedge CLOCK_50);
    reiniciarJogo = 1'b0;
    m_vidas  = 3;
    m_pontos = 0;
    m_fim    = 1'b0;
    m_vit    = 1'b0;
    m_acerto = 1'b0;
    confere(nome);
  endtask

  initial begin
    int soma_acerto;
    reset         = 1'b0;
    tick_mv       = 1'b0;
    pausa         = 1'b0;
    reiniciarJogo = 1'b0;
    limpa();
    empacota();
    m_vidas  = 3;
    m_pontos = 0;
    m_fim    = 1'b0;
    m_vit    = 1'b0;
    m_acerto = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    confere("reset");
    reset = 1'b1;
    @(negedge CLOCK_50);

    limpa();
    quadro("t1_vazio", 1'b0);
    verifica("t1_vidas_abs", int'(vidas), 3);

    limpa();
    xn = 90; yn = 395; bx[7] = 100; by[7] = 400;
    quadro("t2_bala7", 1'b0);
    verifica("t2_vidas_abs", int'(vidas), 2);

    limpa();
    xn = 90; yn = 395;
    bx[0] = 95;  by[0] = 400;
    bx[5] = 110; by[5] = 398;
    bx[19] = 118; by[19] = 408;
    quadro("t3_tres_balas", 1'b0);
    verifica("t3_vidas_abs", int'(vidas), 1);

    limpa();
    xn = 200; yn = 420; bx[12] = 210; by[12] = 425;
    quadro("t4_derrota", 1'b0);
    verifica("t4_fim_abs", int'(fim_jogo), 1);
    verifica("t4_vitoria_abs", int'(vitoria), 0);
    verifica("t4_vidas_abs", int'(vidas), 0);
    quadro("t4_fim_fixo", 1'b0);
    reinicia("t4_reinicio");
    verifica("t4_reinicio_vidas_abs", int'(vidas), 3);

    limpa();
    for (int i = 0; i < N; i++) ev[i] = 1'b0;
    quadro("t5_vitoria", 1'b0);
    verifica("t5_pontos_abs", int'(pontos), 200);
    verifica("t5_vitoria_abs", int'(vitoria), 1);
    gera_aleatorio();
    quadro("t5_fim_fixo", 1'b0);
    reinicia("t5_reinicio");

    limpa();
    xn = 90; yn = 395; bx[2] = 100; by[2] = 400;
    pausa = 1'b1;
    quadro("t6_pausa", 1'b0);

    // Restart in cycle 10 of a frame that would otherwise cost a life.
    limpa();
    xn = 90; yn = 395; bx[3] = 100; by[3] = 400;
    empacota();
    tick_mv = 1'b1;
    @(negedge CLOCK_50);
    tick_mv = 1'b0;
    repeat (9) @(negedge CLOCK_50);
    reiniciarJogo = 1'b1;
    @(negedge CLOCK_50);
    reiniciarJogo = 1'b0;
    verifica("t7_ocupado_c11", int'(ocupado), 0);
    m_vidas = 3; m_pontos = 0; m_fim = 1'b0; m_vit = 1'b0; m_acerto = 1'b0;
    soma_acerto = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge CLOCK_50);
      soma_acerto += int'(acerto_nave);
    end
    verifica("t7_sem_acerto", soma_acerto, 0);
    confere("t7_reinicio_meio");

    // A tick in cycle 15 must not queue a second frame.
    limpa();
    xn = 90; yn = 395; bx[4] = 100; by[4] = 400;
    empacota();
    modelo_quadro();
    tick_mv = 1'b1;
    @(negedge CLOCK_50);
    tick_mv = 1'b0;
    repeat (14) @(negedge CLOCK_50);
    tick_mv = 1'b1;
    @(negedge CLOCK_50);
    tick_mv = 1'b0;
    repeat (6) @(negedge CLOCK_50);
    confere("t8_tick_descartado");
    @(negedge CLOCK_50);
    verifica("t8_ocupado_c23", int'(ocupado), 0);
    @(negedge CLOCK_50);
    verifica("t8_vidas_c24", int'(vidas), m_vidas);

    for (int k = 0; k < 40; k++) begin
      if (m_fim) reinicia("rnd_reinicio");
      gera_aleatorio();
      quadro("rnd", 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/juiz_frota.md
# juiz_frota

Referee for the invader game. It consumes the packed fleet bus produced by the fleet block (enemy positions, enemy bullets, alive mask) together with the ship position. Once per movement tick it scans the 20 enemy slots sequentially and produces lives, score, ship-hit pulse and end-of-game flags for the HUD and game-control logic. It is the reading end of the fleet bus and runs on the system clock only.

## Interface
- N_INIMIGOS, 20: enemy/bullet slots on the bus
- VIDAS_INI, 3: lives after reset or restart (1..3)
- LARG_NAVE, 32: ship box width, px
- ALT_NAVE, 16: ship box height, px
- TAM_BOLA, 4: bullet box side, px
- ALT_INIMIGO, 16: enemy box height, px

Ports (one clock; reset is asynchronous and active-low):
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-low
- tick_mv  in  1  one-cycle frame pulse, synchronous to CLOCK_50
- pausa  in  1  ticks ignored while high
- reiniciarJogo  in  1  synchronous restart, level
- inimigo_x, inimigo_y  in  200 each  slot i at [10i+9:10i]
- x_bola, y_bola  in  200 each  enemy bullet slot i at [10i+9:10i]
- vivo  in  [0:19]  bit i = enemy i alive
- x_nave, y_nave  in  10 each  ship top-left
- vidas  out  2  lives remaining
- pontos  out  8  score = 10 × enemies dead
- acerto_nave  out  1  one-cycle pulse, ship lost a life
- fim_jogo  out  1  sticky, game over
- vitoria  out  1  sticky, valid with fim_jogo
- ocupado  out  1  high in SCAN/REPORT

## Operation
- States: IDLE, SCAN, REPORT, FIM.
- IDLE: tick_mv=1 and pausa=0 → snapshot all bus inputs and the ship position into internal registers, clear accumulators, slot counter=0, go to SCAN. tick_mv with pausa=1 is dropped.
- SCAN: one slot per cycle, counter 0..19. Per slot:
  - The bullet is live iff y_bola slot < 480.
  - A live bullet box overlapping the ship box sets hit.
  - A clear vivo bit increments the dead count.
  - An alive enemy with y+ALT_INIMIGO ≥ y_nave sets invasion.
  - Counter 19 → REPORT.
- Overlap test: bx < xn+LARG_NAVE && bx+TAM_BOLA > xn, same form for y. All sums are 11-bit, so there is no wrap.
- REPORT (one cycle):
  - If hit: vidas−1, saturating at 0, and pulse acerto_nave. At most one life is lost per frame, however many bullets overlap.
  - pontos = dead×10, computed as (d<<3)+(d<<1).
  - Dead count = 20 → FIM with vitoria=1.
  - Otherwise, new vidas = 0 or invasion → FIM with vitoria=0.
  - Otherwise → IDLE.
  - Victory takes precedence over loss in the same frame.
- FIM: fim_jogo=1; ticks are ignored; state is held until reiniciarJogo.
- reiniciarJogo=1 in any state, including mid-SCAN: on the next edge go to IDLE; vidas=VIDAS_INI; pontos, flags and accumulators are cleared. It has priority over tick_mv.
- pausa rising mid-SCAN does not stall the scan; the frame completes.
- tick_mv arriving in SCAN or REPORT is dropped. No queueing.

## Timing
- Reset values: vidas=VIDAS_INI, pontos=0, acerto_nave=0, fim_jogo=0, vitoria=0, ocupado=0, state IDLE.
- Cycle 0: tick_mv sampled high in IDLE. Snapshot is taken on the edge ending cycle 0.
- Cycles 1–20: SCAN, slot i in cycle i+1. ocupado=1 in cycles 1–21.
- Cycle 21: REPORT.
- From cycle 22: new vidas, pontos and flags are valid. acerto_nave is high in cycle 22 only. The earliest next accepted tick is in cycle 22.
- Bus changes after cycle 0 do not affect the frame in progress.
- All outputs are registered; no combinational input→output paths.

## Configuration
- JUIZ_INVASAO_EN defined: the invasion check is compiled in, and invasion ends the game with vitoria=0.
- Not defined: the invasion logic is absent and the game ends only on vidas=0 or all enemies dead. Everything else is unchanged.

## Structure
- Shared package juiz_pkg holds:
  - the state enum (IDLE, SCAN, REPORT, FIM);
  - N_INIMIGOS;
  - ALT_TELA=480, the live-bullet threshold;
  - LARG_TELA=640;
  - the slot field width (10).
- Sub-module colisao_caixa: combinational 11-bit AABB overlap, instantiated once for the bullet/ship test.

## Test plan
- Reset, all vivo=1, no live bullets (y=480), tick → cycle 22: vidas=3, pontos=0, acerto_nave=0, ocupado low.
- Bullet slot 7 at (100,400) and ship at (90,395), tick → acerto_nave pulse in cycle 22 only, vidas=2.
- Three bullets overlapping the ship in one frame → vidas drops by exactly 1.
- vivo=20'h0, tick → fim_jogo=1, vitoria=1, pontos=200. A further tick leaves everything unchanged.
- vidas=1 plus a hit, tick → vidas=0, fim_jogo=1, vitoria=0. Then reiniciarJogo → vidas=3, flags 0.
- reiniciarJogo in cycle 10 of SCAN → IDLE next cycle with no REPORT update. A tick issued in cycle 15 of a normal scan is dropped.
